// File: rtl/kbd_disp_pkg.sv
// Shared constants and decode state type for the
// keyboard entry / display path.
package kbd_disp_pkg;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   typedef enum logic [1:0] {
      IDLE,
      BRK,
      EXT,
      EXTBRK
   } dec_state_t;

endpackage

// File: rtl/display_scanner.sv
// Time-multiplexes the entry buffer onto the
// shared 7-segment display, one slot per period.
module display_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_DIGITS-1:0][3:0] entry_buf,
   input  logic [2:0]                 entry_count,
   output logic [NUM_DIGITS-1:0]      anode,
   output logic [3:0]                 disp_digit,
   output logic                       disp_blank
);

   localparam int RW =
      (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int SW = $clog2(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] ONE = 1;

   logic [RW-1:0] ref_cnt;
   logic [SW-1:0] slot;
   logic [SW-1:0] slot_next;
   logic          wrap;

   // Slot wrap detection and next-slot selection
   always_comb begin
      wrap = (ref_cnt == RW'(REFRESH_DIV - 1));
      if (slot == SW'(NUM_DIGITS - 1))
         slot_next = '0;
      else
         slot_next = slot + 1'b1;
   end

   // Refresh counter, slot index and display registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_cnt    <= '0;
         slot       <= '0;
         anode      <= '1;
         disp_digit <= 4'h0;
         disp_blank <= 1'b1;
      end else if (wrap) begin
         ref_cnt    <= '0;
         slot       <= slot_next;
         anode      <= ~(ONE << slot_next);
         disp_digit <= entry_buf[slot_next];
         disp_blank <= (3'(slot_next) >= entry_count);
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/key_entry_controller.sv
// Decodes PS/2 make/break events into a digit entry
// buffer and drives the multiplexed display.
module key_entry_controller
   import kbd_disp_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int PREFIX_TIMEOUT = 2**20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            scan_code,
   input  logic                  scan_ready,
   input  logic [3:0]            digit_in,
   input  logic                  digit_valid,
   output logic [3:0]            disp_digit,
   output logic                  disp_blank,
   output logic [NUM_DIGITS-1:0] anode,
   output logic                  key_pressed,
   output logic [2:0]            entry_count
);

   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

   dec_state_t state, state_nxt;
   logic [7:0]    held_code;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          make_acc;
   logic          clr_held;
   logic [NUM_DIGITS-1:0][3:0] entry_buf;

   // Decode state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode, make acceptance, break release
   always_comb begin
      state_nxt = state;
      make_acc  = 1'b0;
      clr_held  = 1'b0;
      tmo_hit   = (tmo_cnt == TW'(PREFIX_TIMEOUT - 1));
      if (scan_ready) begin
         case (state)
            IDLE: begin
               if (scan_code == SC_BREAK)
                  state_nxt = BRK;
               else if (scan_code == SC_EXT)
                  state_nxt = EXT;
               else if (scan_code != held_code)
                  make_acc = 1'b1;
            end
            BRK: begin
               clr_held  = (scan_code == held_code);
               state_nxt = IDLE;
            end
            EXT: begin
               if (scan_code == SC_BREAK)
                  state_nxt = EXTBRK;
               else
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (state != IDLE && tmo_hit) begin
         state_nxt = IDLE;
      end
   end

   // Prefix timeout: counts idle cycles spent in a prefix state
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tmo_cnt <= '0;
      else if (state == IDLE || scan_ready)
         tmo_cnt <= '0;
      else if (!tmo_hit)
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Held code, entry buffer edits and key_pressed pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held_code   <= 8'h00;
         entry_buf   <= '0;
         entry_count <= 3'd0;
         key_pressed <= 1'b0;
      end else begin
         key_pressed <= make_acc;
         if (clr_held)
            held_code <= 8'h00;
         if (make_acc) begin
            held_code <= scan_code;
            case (1'b1)
               digit_valid: begin
                  entry_buf <= {entry_buf[NUM_DIGITS-2:0],
                                digit_in};
                  if (entry_count != 3'(NUM_DIGITS))
                     entry_count <= entry_count + 3'd1;
               end
               (scan_code == SC_BKSP): begin
                  if (entry_count != 3'd0) begin
                     entry_buf <= {4'h0,
                                   entry_buf[NUM_DIGITS-1:1]};
                     entry_count <= entry_count - 3'd1;
                  end
               end
               (scan_code == SC_ESC): begin
                  entry_buf   <= '0;
                  entry_count <= 3'd0;
               end
               default: ;
            endcase
         end
      end
   end

   display_scanner #(
      .NUM_DIGITS (NUM_DIGITS),
      .REFRESH_DIV(REFRESH_DIV)
   ) u_scan (
      .clk        (clk),
      .reset      (reset),
      .entry_buf  (entry_buf),
      .entry_count(entry_count),
      .anode      (anode),
      .disp_digit (disp_digit),
      .disp_blank (disp_blank)
   );

endmodule

// File: tb/tb_key_entry_controller.sv
// Directed bench for key_entry_controller with a
// vector table plus hand-written corner sequences.
module tb_key_entry_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] scan_code;
   logic       scan_ready;
   logic [3:0] digit_in;
   logic       digit_valid;
   logic [3:0] disp_digit;
   logic       disp_blank;
   logic [3:0] anode;
   logic       key_pressed;
   logic [2:0] entry_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] code;
      logic [3:0] dig;
      logic       dv;
      logic       kp;
      logic [2:0] cnt;
   } vec_t;

   vec_t vt[$];

   key_entry_controller #(
      .NUM_DIGITS    (4),
      .REFRESH_DIV   (4),
      .PREFIX_TIMEOUT(16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .scan_code  (scan_code),
      .scan_ready (scan_ready),
      .digit_in   (digit_in),
      .digit_valid(digit_valid),
      .disp_digit (disp_digit),
      .disp_blank (disp_blank),
      .anode      (anode),
      .key_pressed(key_pressed),
      .entry_count(entry_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] c,
                       input logic [3:0] d,
                       input logic v);
      @(negedge clk);
      scan_code   = c;
      digit_in    = d;
      digit_valid = v;
      scan_ready  = 1'b1;
      @(negedge clk);
      scan_ready  = 1'b0;
      digit_valid = 1'b0;
   endtask

   task automatic apply(input vec_t x, input string nm);
      send(x.code, x.dig, x.dv);
      chk({nm, " key_pressed"}, int'(key_pressed), int'(x.kp));
      chk({nm, " entry_count"}, int'(entry_count), int'(x.cnt));
   endtask

   function automatic vec_t mk(input logic [7:0] c,
                               input logic [3:0] d,
                               input logic v,
                               input logic k,
                               input logic [2:0] n);
      vec_t r;
      r.code = c; r.dig = d; r.dv = v;
      r.kp = k; r.cnt = n;
      return r;
   endfunction

   task automatic add_key(input logic [7:0] c,
                          input logic [3:0] d,
                          input logic [2:0] n);
      vt.push_back(mk(c, d, 1'b1, 1'b1, n));
      vt.push_back(mk(8'hF0, 4'h0, 1'b0, 1'b0, n));
      vt.push_back(mk(c, d, 1'b1, 1'b0, n));
   endtask

   task automatic add_cmd(input logic [7:0] c,
                          input logic [2:0] n);
      vt.push_back(mk(c, 4'h0, 1'b0, 1'b1, n));
      vt.push_back(mk(8'hF0, 4'h0, 1'b0, 1'b0, n));
      vt.push_back(mk(c, 4'h0, 1'b0, 1'b0, n));
   endtask

   task automatic run_table(input string nm);
      for (int i = 0; i < vt.size(); i++)
         apply(vt[i], $sformatf("%s[%0d]", nm, i));
      vt.delete();
   endtask

   task automatic chk_slot(input int s,
                           input int d, input int b);
      logic [3:0] pat;
      bit hit = 0;
      pat = ~(4'b0001 << s);
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk);
         if (anode == pat) hit = 1;
      end
      chk($sformatf("slot%0d seen", s), int'(hit), 1);
      if (hit) begin
         chk($sformatf("slot%0d digit", s), int'(disp_digit), d);
         chk($sformatf("slot%0d blank", s), int'(disp_blank), b);
      end
   endtask

   task automatic chk_disp(input int d0, input int d1,
                           input int d2, input int d3,
                           input int n);
      repeat (20) @(negedge clk);
      chk_slot(0, d0, (n <= 0) ? 1 : 0);
      chk_slot(1, d1, (n <= 1) ? 1 : 0);
      chk_slot(2, d2, (n <= 2) ? 1 : 0);
      chk_slot(3, d3, (n <= 3) ? 1 : 0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " disp_digit"}, int'(disp_digit), 0);
      chk({nm, " disp_blank"}, int'(disp_blank), 1);
      chk({nm, " anode"}, int'(anode), 15);
      chk({nm, " key_pressed"}, int'(key_pressed), 0);
      chk({nm, " entry_count"}, int'(entry_count), 0);
   endtask

   int kp_cnt = 0;
   always @(negedge clk)
      if (key_pressed) kp_cnt++;

   initial begin
      reset       = 1'b1;
      scan_code   = 8'h00;
      scan_ready  = 1'b0;
      digit_in    = 4'h0;
      digit_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("anode idle after reset", int'(anode), 15);

      // keys 1,2,3 with breaks
      kp_cnt = 0;
      add_key(8'h16, 4'd1, 3'd1);
      add_key(8'h1E, 4'd2, 3'd2);
      add_key(8'h26, 4'd3, 3'd3);
      run_table("t1");
      chk("t1 pulses", kp_cnt, 3);
      chk_disp(3, 2, 1, 0, 3);

      // typematic repeat filtering
      add_cmd(8'h76, 3'd0);
      vt.push_back(mk(8'h16, 4'd1, 1'b1, 1'b1, 3'd1));
      vt.push_back(mk(8'h16, 4'd1, 1'b1, 1'b0, 3'd1));
      vt.push_back(mk(8'h16, 4'd1, 1'b1, 1'b0, 3'd1));
      vt.push_back(mk(8'hF0, 4'd0, 1'b0, 1'b0, 3'd1));
      vt.push_back(mk(8'h16, 4'd1, 1'b1, 1'b0, 3'd1));
      vt.push_back(mk(8'h16, 4'd1, 1'b1, 1'b1, 3'd2));
      vt.push_back(mk(8'hF0, 4'd0, 1'b0, 1'b0, 3'd2));
      vt.push_back(mk(8'h16, 4'd1, 1'b1, 1'b0, 3'd2));
      run_table("t2");

      // overflow discards the oldest digit
      add_cmd(8'h76, 3'd0);
      add_key(8'h16, 4'd1, 3'd1);
      add_key(8'h1E, 4'd2, 3'd2);
      add_key(8'h26, 4'd3, 3'd3);
      add_key(8'h25, 4'd4, 3'd4);
      add_key(8'h2E, 4'd5, 3'd4);
      run_table("t3");
      chk_disp(5, 4, 3, 2, 4);

      // backspace down to and past empty
      add_cmd(8'h66, 3'd3);
      add_cmd(8'h66, 3'd2);
      run_table("t4a");
      chk_disp(3, 2, 0, 0, 2);
      add_cmd(8'h66, 3'd1);
      add_cmd(8'h66, 3'd0);
      add_cmd(8'h66, 3'd0);
      add_key(8'h16, 4'd1, 3'd1);
      add_key(8'h1E, 4'd2, 3'd2);
      add_key(8'h26, 4'd3, 3'd3);
      add_key(8'h25, 4'd4, 3'd4);
      add_cmd(8'h76, 3'd0);
      run_table("t4b");
      chk_disp(0, 0, 0, 0, 0);

      // extended make ignored, prefix timeout
      apply(mk(8'hE0, 4'd0, 1'b0, 1'b0, 3'd0), "t5 e0");
      apply(mk(8'h16, 4'd1, 1'b1, 1'b0, 3'd0), "t5 ext");
      send(8'hF0, 4'd0, 1'b0);
      repeat (20) @(negedge clk);
      apply(mk(8'h1E, 4'd2, 1'b1, 1'b1, 3'd1), "t5 tmo");
      apply(mk(8'hE0, 4'd0, 1'b0, 1'b0, 3'd1), "t5 e0b");
      apply(mk(8'hF0, 4'd0, 1'b0, 1'b0, 3'd1), "t5 e0f0");
      apply(mk(8'h26, 4'd3, 1'b1, 1'b0, 3'd1), "t5 extbrk");
      apply(mk(8'h26, 4'd3, 1'b1, 1'b1, 3'd2), "t5 after");

      // reset while in BRK with three digits held
      apply(mk(8'h25, 4'd4, 1'b1, 1'b1, 3'd3), "t6 fill");
      send(8'hF0, 4'd0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("t6 reset");
      reset = 1'b0;
      apply(mk(8'h16, 4'd1, 1'b1, 1'b1, 3'd1), "t6 make");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
